// File: rtl/result_uart_tx.sv
// 8N1 UART transmitter for the test-flow result word: optional sync byte, then the
// payload bytes LS byte first, with a one-cycle txFinish pulse after the last stop bit.
module result_uart_tx #(
    parameter int unsigned CLKS_PER_BIT = 434,
    parameter int unsigned NUM_BYTES    = 4,
    parameter int unsigned SEND_HEADER  = 1,
    parameter logic [7:0]  HEADER_BYTE  = 8'hA5
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   start_tx,
    input  logic [8*NUM_BYTES-1:0] result_data,
    output logic                   tx,
    output logic                   busy,
    output logic                   txFinish
);

    localparam int unsigned TOTAL  = NUM_BYTES + ((SEND_HEADER != 0) ? 1 : 0);
    localparam int unsigned DATA_W = 8 * NUM_BYTES;
    localparam int unsigned BAUD_W = $clog2(CLKS_PER_BIT);
    localparam int unsigned IDX_W  = $clog2(TOTAL + 1);

    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
    localparam logic [IDX_W-1:0]  LAST_BYTE = IDX_W'(TOTAL - 1);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t             r_state;
    logic [BAUD_W-1:0]  r_baud;
    logic [2:0]         r_bitIdx;
    logic [IDX_W-1:0]   r_byteIdx;
    logic [7:0]         r_shift;
    logic [DATA_W-1:0]  r_data;
    logic               r_tx;
    logic               r_busy;
    logic               r_txFinish;

    state_t             w_state;
    logic [BAUD_W-1:0]  w_baud;
    logic [2:0]         w_bitIdx;
    logic [IDX_W-1:0]   w_byteIdx;
    logic [7:0]         w_shift;
    logic [DATA_W-1:0]  w_data;
    logic               w_tx;
    logic               w_busy;
    logic               w_txFinish;
    logic               w_bitDone;

    assign w_bitDone = (r_baud == BAUD_LAST);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= IDLE;
            r_baud     <= '0;
            r_bitIdx   <= '0;
            r_byteIdx  <= '0;
            r_shift    <= '0;
            r_data     <= '0;
            r_tx       <= 1'b1;
            r_busy     <= 1'b0;
            r_txFinish <= 1'b0;
        end else begin
            r_state    <= w_state;
            r_baud     <= w_baud;
            r_bitIdx   <= w_bitIdx;
            r_byteIdx  <= w_byteIdx;
            r_shift    <= w_shift;
            r_data     <= w_data;
            r_tx       <= w_tx;
            r_busy     <= w_busy;
            r_txFinish <= w_txFinish;
        end
    end

    // r_shift holds the byte on the wire; r_data holds the payload bytes still to be sent.
    always_comb begin
        w_state    = r_state;
        w_baud     = r_baud;
        w_bitIdx   = r_bitIdx;
        w_byteIdx  = r_byteIdx;
        w_shift    = r_shift;
        w_data     = r_data;
        w_tx       = r_tx;
        w_busy     = r_busy;
        w_txFinish = 1'b0;

        unique case (r_state)
            IDLE: begin
                w_baud = '0;
                if (start_tx) begin
                    w_state   = START;
                    w_bitIdx  = '0;
                    w_byteIdx = '0;
                    w_busy    = 1'b1;
                    w_tx      = 1'b0;
                    if (SEND_HEADER != 0) begin
                        w_shift = HEADER_BYTE;
                        w_data  = result_data;
                    end else begin
                        w_shift = result_data[7:0];
                        w_data  = result_data >> 8;
                    end
                end
            end

            START: begin
                if (w_bitDone) begin
                    w_baud   = '0;
                    w_state  = DATA;
                    w_bitIdx = '0;
                    w_tx     = r_shift[0];
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end

            DATA: begin
                if (w_bitDone) begin
                    w_baud = '0;
                    if (r_bitIdx == 3'd7) begin
                        w_state = STOP;
                        w_tx    = 1'b1;
                    end else begin
                        w_bitIdx = r_bitIdx + 3'd1;
                        w_shift  = r_shift >> 1;
                        w_tx     = r_shift[1];
                    end
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end

            STOP: begin
                if (w_bitDone) begin
                    w_baud = '0;
                    if (r_byteIdx == LAST_BYTE) begin
                        w_state    = IDLE;
                        w_busy     = 1'b0;
                        w_txFinish = 1'b1;
                        w_tx       = 1'b1;
                    end else begin
                        w_state   = START;
                        w_byteIdx = r_byteIdx + 1'b1;
                        w_shift   = r_data[7:0];
                        w_data    = r_data >> 8;
                        w_tx      = 1'b0;
                    end
                end else begin
                    w_baud = r_baud + 1'b1;
                end
            end

            default: begin
                w_state = IDLE;
                w_baud  = '0;
                w_tx    = 1'b1;
                w_busy  = 1'b0;
            end
        endcase
    end

    assign tx       = r_tx;
    assign busy     = r_busy;
    assign txFinish = r_txFinish;

endmodule

// File: tb/tb_result_uart_tx.sv
// Directed bench for result_uart_tx: one instance with the sync byte, one without,
// both at four clocks per bit so whole frames stay short.
module tb_result_uart_tx;

    localparam int C = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        startA = 1'b0;
    logic [15:0] dataA = '0;
    logic        txA, busyA, finA;
    logic        startB = 1'b0;
    logic [15:0] dataB = '0;
    logic        txB, busyB, finB;

    int vectors = 0;
    int miscompares = 0;

    always #5 clk = ~clk;

    result_uart_tx #(
        .CLKS_PER_BIT(C), .NUM_BYTES(2), .SEND_HEADER(1), .HEADER_BYTE(8'hA5)
    ) dutA (
        .clk(clk), .reset(reset), .start_tx(startA), .result_data(dataA),
        .tx(txA), .busy(busyA), .txFinish(finA)
    );

    result_uart_tx #(
        .CLKS_PER_BIT(C), .NUM_BYTES(2), .SEND_HEADER(0), .HEADER_BYTE(8'hA5)
    ) dutB (
        .clk(clk), .reset(reset), .start_tx(startB), .result_data(dataB),
        .tx(txB), .busy(busyB), .txFinish(finB)
    );

    // Expected line level at each bit time: start 0, data LSB first, stop 1.
    function automatic logic [39:0] frameBits(input logic [7:0] b0, input logic [7:0] b1,
                                              input logic [7:0] b2, input int nBytes);
        logic [39:0] r;
        logic [7:0]  cur;
        r = '0;
        for (int n = 0; n < nBytes * 10; n++) begin
            case (n / 10)
                0:       cur = b0;
                1:       cur = b1;
                default: cur = b2;
            endcase
            if (n % 10 == 0)      r[n] = 1'b0;
            else if (n % 10 == 9) r[n] = 1'b1;
            else                  r[n] = cur[n % 10 - 1];
        end
        return r;
    endfunction

    task automatic startFrame(input int which, input logic [15:0] d);
        @(negedge clk);
        if (which == 0) begin startA = 1'b1; dataA = d; end
        else begin startB = 1'b1; dataB = d; end
        @(posedge clk);
        #1;
        startA = 1'b0;
        startB = 1'b0;
    endtask

    // Samples one frame starting just after E0; cycle c is sampled on the falling edge after E0+c.
    task automatic captureFrame(input int which, input int nBits, input int pulseAt,
                                input bit scramble, input bit armB2b, input logic [15:0] nextData,
                                output logic [39:0] bits, output int busyCycles,
                                output int finCycle, output int finCount,
                                output logic finTx, output logic firstTx);
        logic t, b, f;
        bits = '0; busyCycles = 0; finCycle = -1; finCount = 0; finTx = 1'b0; firstTx = 1'b1;
        for (int c = 0; c < nBits * C + 6; c++) begin
            @(negedge clk);
            if (which == 0) begin t = txA; b = busyA; f = finA; end
            else begin t = txB; b = busyB; f = finB; end
            if (c == 0) firstTx = t;
            if ((c % C == C / 2) && (c / C < nBits)) bits[c / C] = t;
            if (b) busyCycles++;
            if (f) begin
                finCount++;
                if (finCycle < 0) begin finCycle = c; finTx = t; end
            end
            if (scramble) begin
                if (which == 0) dataA = 16'($urandom); else dataB = 16'($urandom);
            end
            if (c == pulseAt - 1) begin
                if (which == 0) begin startA = 1'b1; dataA = 16'hFFFF; end
                else begin startB = 1'b1; dataB = 16'hFFFF; end
            end
            if (c == pulseAt) begin startA = 1'b0; startB = 1'b0; end
            if (armB2b && f) begin
                if (which == 0) begin startA = 1'b1; dataA = nextData; end
                else begin startB = 1'b1; dataB = nextData; end
                @(posedge clk);
                #1;
                startA = 1'b0;
                startB = 1'b0;
                return;
            end
        end
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        vectors++;
        if ({txA, busyA, finA} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL reset_A: got tx/busy/fin=%b required 100", {txA, busyA, finA});
        end
        vectors++;
        if ({txB, busyB, finB} !== 3'b100) begin
            miscompares++;
            $display("[TB] FAIL reset_B: got tx/busy/fin=%b required 100", {txB, busyB, finB});
        end
        reset = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic test_basic();
        logic [39:0] bits; int bc, fc, fn; logic ft, t0;
        startFrame(0, 16'h1234);
        captureFrame(0, 30, -1, 1'b0, 1'b0, 16'h0, bits, bc, fc, fn, ft, t0);
        vectors++;
        if (bits !== frameBits(8'hA5, 8'h34, 8'h12, 3)) begin
            miscompares++;
            $display("[TB] FAIL basic_bits: got %h required %h", bits, frameBits(8'hA5, 8'h34, 8'h12, 3));
        end
        vectors++;
        if (bc !== 120) begin miscompares++; $display("[TB] FAIL basic_busy: got %0d cycles required 120", bc); end
        vectors++;
        if (fc !== 120) begin miscompares++; $display("[TB] FAIL basic_finish_cycle: got %0d required 120", fc); end
        vectors++;
        if (fn !== 1) begin miscompares++; $display("[TB] FAIL basic_finish_count: got %0d required 1", fn); end
        vectors++;
        if (ft !== 1'b1) begin miscompares++; $display("[TB] FAIL basic_tx_at_finish: got %b required 1", ft); end
    endtask

    task automatic test_no_header();
        logic [39:0] bits; int bc, fc, fn; logic ft, t0;
        startFrame(1, 16'h00FF);
        captureFrame(1, 20, -1, 1'b0, 1'b0, 16'h0, bits, bc, fc, fn, ft, t0);
        vectors++;
        if (bits !== frameBits(8'hFF, 8'h00, 8'h00, 2)) begin
            miscompares++;
            $display("[TB] FAIL nohdr_bits: got %h required %h", bits, frameBits(8'hFF, 8'h00, 8'h00, 2));
        end
        vectors++;
        if (fc !== 80) begin miscompares++; $display("[TB] FAIL nohdr_finish_cycle: got %0d required 80", fc); end
        vectors++;
        if (bc !== 80) begin miscompares++; $display("[TB] FAIL nohdr_busy: got %0d cycles required 80", bc); end
        vectors++;
        if (fn !== 1) begin miscompares++; $display("[TB] FAIL nohdr_finish_count: got %0d required 1", fn); end
    endtask

    task automatic test_ignored_start();
        logic [39:0] bits; int bc, fc, fn; logic ft, t0;
        startFrame(0, 16'h1234);
        captureFrame(0, 30, 50, 1'b0, 1'b0, 16'h0, bits, bc, fc, fn, ft, t0);
        vectors++;
        if (bits !== frameBits(8'hA5, 8'h34, 8'h12, 3)) begin
            miscompares++;
            $display("[TB] FAIL ignored_bits: got %h required %h", bits, frameBits(8'hA5, 8'h34, 8'h12, 3));
        end
        vectors++;
        if (fn !== 1) begin miscompares++; $display("[TB] FAIL ignored_finish_count: got %0d required 1", fn); end
        vectors++;
        if (fc !== 120) begin miscompares++; $display("[TB] FAIL ignored_finish_cycle: got %0d required 120", fc); end
    endtask

    task automatic test_back_to_back();
        logic [39:0] bits; int bc, fc, fn; logic ft, t0;
        startFrame(0, 16'h1234);
        captureFrame(0, 30, -1, 1'b0, 1'b1, 16'hBEEF, bits, bc, fc, fn, ft, t0);
        vectors++;
        if (fc !== 120 || bc !== 120) begin
            miscompares++;
            $display("[TB] FAIL b2b_first_frame: got finish %0d busy %0d required 120 120", fc, bc);
        end
        captureFrame(0, 30, -1, 1'b0, 1'b0, 16'h0, bits, bc, fc, fn, ft, t0);
        vectors++;
        if (t0 !== 1'b0 || bc !== 120) begin
            miscompares++;
            $display("[TB] FAIL b2b_restart: got tx0 %b busy %0d required 0 120", t0, bc);
        end
        vectors++;
        if (bits !== frameBits(8'hA5, 8'hEF, 8'hBE, 3)) begin
            miscompares++;
            $display("[TB] FAIL b2b_bits: got %h required %h", bits, frameBits(8'hA5, 8'hEF, 8'hBE, 3));
        end
        vectors++;
        if (fc !== 120 || fn !== 1) begin
            miscompares++;
            $display("[TB] FAIL b2b_second_finish: got cycle %0d count %0d required 120 1", fc, fn);
        end
    endtask

    task automatic test_isolation();
        logic [39:0] bits; int bc, fc, fn; logic ft, t0;
        startFrame(0, 16'hC3A9);
        captureFrame(0, 30, -1, 1'b1, 1'b0, 16'h0, bits, bc, fc, fn, ft, t0);
        vectors++;
        if (bits !== frameBits(8'hA5, 8'hA9, 8'hC3, 3)) begin
            miscompares++;
            $display("[TB] FAIL isolation_bits: got %h required %h", bits, frameBits(8'hA5, 8'hA9, 8'hC3, 3));
        end
        dataA = '0;
    endtask

    task automatic test_reset_mid_frame();
        logic [39:0] bits; int bc, fc, fn; logic ft, t0;
        int finSeen, busySeen;
        startFrame(0, 16'h5A5A);
        repeat (36) @(posedge clk);
        #1 reset = 1'b0;
        #1;
        vectors++;
        if (txA !== 1'b1 || busyA !== 1'b0) begin
            miscompares++;
            $display("[TB] FAIL midreset_immediate: got tx %b busy %b required 1 0", txA, busyA);
        end
        repeat (2) @(posedge clk);
        #1 reset = 1'b1;
        finSeen = 0; busySeen = 0;
        for (int c = 0; c < 100; c++) begin
            @(negedge clk);
            if (finA) finSeen++;
            if (busyA || !txA) busySeen++;
        end
        vectors++;
        if (finSeen !== 0 || busySeen !== 0) begin
            miscompares++;
            $display("[TB] FAIL midreset_idle: got finish %0d active %0d required 0 0", finSeen, busySeen);
        end
        startFrame(0, 16'h8001);
        captureFrame(0, 30, -1, 1'b0, 1'b0, 16'h0, bits, bc, fc, fn, ft, t0);
        vectors++;
        if (bits !== frameBits(8'hA5, 8'h01, 8'h80, 3)) begin
            miscompares++;
            $display("[TB] FAIL midreset_new_bits: got %h required %h", bits, frameBits(8'hA5, 8'h01, 8'h80, 3));
        end
        vectors++;
        if (fc !== 120 || fn !== 1) begin
            miscompares++;
            $display("[TB] FAIL midreset_new_finish: got cycle %0d count %0d required 120 1", fc, fn);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_no_header();
        test_ignored_start();
        test_back_to_back();
        test_isolation();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
